// File: rtl/alu_operand_aligner_if.sv
// Command bus between the ALU stimulus driver and the operand aligner, plus
// the aligned issue port toward the execution core.
interface alu_operand_aligner_if #(
    parameter int WIDTH  = 8,
    parameter int CWIDTH = 4
);
    // Request side. A command is presented whenever inp_valid != 0 and ce = 1;
    // the aligner has no back-pressure, so every such sample is consumed.
    logic              ce;
    logic              mode;
    logic [CWIDTH-1:0] cmd;
    logic [1:0]        inp_valid;
    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic              cin;

    // Issue side: issue_valid and err are one-cycle strobes, never both high.
    logic              issue_valid;
    logic              issue_mode;
    logic [CWIDTH-1:0] issue_cmd;
    logic              issue_cin;
    logic [WIDTH-1:0]  issue_opa;
    logic [WIDTH-1:0]  issue_opb;
    logic              err;
    logic              busy;
    logic [1:0]        state_dbg;

    modport master (
        output ce, mode, cmd, inp_valid, opa, opb, cin,
        input  issue_valid, issue_mode, issue_cmd, issue_cin,
               issue_opa, issue_opb, err, busy, state_dbg
    );

    modport slave (
        input  ce, mode, cmd, inp_valid, opa, opb, cin,
        output issue_valid, issue_mode, issue_cmd, issue_cin,
               issue_opa, issue_opb, err, busy, state_dbg
    );
endinterface

// File: rtl/alu_operand_aligner.sv
// Collects operands that may arrive in different cycles and emits one aligned
// operation issue per command, or an error strobe for illegal/timed-out commands.
module alu_operand_aligner #(
    parameter int WIDTH   = 8,
    parameter int CWIDTH  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_operand_aligner_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_A = 2'd1,
        S_WAIT_B = 2'd2
    } state_t;

    localparam logic [4:0] TIMEOUT_CNT = 5'(TIMEOUT);

    state_t            r_state;
    state_t            w_next_state;
    logic [4:0]        r_cnt;
    logic [4:0]        w_cnt_next;

    logic [WIDTH-1:0]  r_cap_opa, r_cap_opb, w_cap_opa, w_cap_opb;
    logic [CWIDTH-1:0] r_cap_cmd, w_cap_cmd;
    logic              r_cap_mode, r_cap_cin, w_cap_mode, w_cap_cin;

    logic              r_issue_valid, r_err;
    logic              r_issue_mode, r_issue_cin;
    logic [CWIDTH-1:0] r_issue_cmd;
    logic [WIDTH-1:0]  r_issue_opa, r_issue_opb;

    logic              w_issue, w_err;
    logic              w_iss_mode, w_iss_cin;
    logic [CWIDTH-1:0] w_iss_cmd;
    logic [WIDTH-1:0]  w_iss_opa, w_iss_opb;

    logic              w_need_a, w_need_b, w_illegal;
    logic [31:0]       w_cmd_ext;

    assign w_cmd_ext = 32'(bus.cmd);

    // Operand need of the command on the bus; only consulted in IDLE.
    always_comb begin
        w_need_a  = 1'b0;
        w_need_b  = 1'b0;
        w_illegal = 1'b0;
        if (bus.mode) begin
            case (w_cmd_ext)
                32'd4, 32'd5: w_need_a = 1'b1;
                32'd6, 32'd7: w_need_b = 1'b1;
                32'd0, 32'd1, 32'd2, 32'd3, 32'd8, 32'd9, 32'd10: begin
                    w_need_a = 1'b1;
                    w_need_b = 1'b1;
                end
                default: w_illegal = 1'b1;
            endcase
        end else begin
            case (w_cmd_ext)
                32'd6, 32'd8, 32'd10: w_need_a = 1'b1;
                32'd7, 32'd9, 32'd11: w_need_b = 1'b1;
                32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd12, 32'd13: begin
                    w_need_a = 1'b1;
                    w_need_b = 1'b1;
                end
                default: w_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_issue      = 1'b0;
        w_err        = 1'b0;
        w_iss_opa    = r_cap_opa;
        w_iss_opb    = r_cap_opb;
        w_iss_cmd    = r_cap_cmd;
        w_iss_mode   = r_cap_mode;
        w_iss_cin    = r_cap_cin;
        w_cap_opa    = r_cap_opa;
        w_cap_opb    = r_cap_opb;
        w_cap_cmd    = r_cap_cmd;
        w_cap_mode   = r_cap_mode;
        w_cap_cin    = r_cap_cin;

        case (r_state)
            S_IDLE: begin
                w_iss_cmd  = bus.cmd;
                w_iss_mode = bus.mode;
                w_iss_cin  = bus.cin;
                w_iss_opa  = w_need_a ? bus.opa : '0;
                w_iss_opb  = w_need_b ? bus.opb : '0;
                if (bus.inp_valid != 2'b00) begin
                    if (w_illegal) begin
                        w_err = 1'b1;
                    end else if (w_need_a && w_need_b) begin
                        if (bus.inp_valid == 2'b11) begin
                            w_issue = 1'b1;
                        end else begin
                            // First half of a split command: park it and wait.
                            w_cap_cmd  = bus.cmd;
                            w_cap_mode = bus.mode;
                            w_cap_cin  = bus.cin;
                            w_cap_opa  = bus.inp_valid[0] ? bus.opa : '0;
                            w_cap_opb  = bus.inp_valid[1] ? bus.opb : '0;
                            w_cnt_next = '0;
                            w_next_state = bus.inp_valid[0] ? S_WAIT_B : S_WAIT_A;
                        end
                    end else if ((w_need_a && bus.inp_valid[0]) ||
                                 (w_need_b && bus.inp_valid[1])) begin
                        w_issue = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_WAIT_A, S_WAIT_B: begin
                if (r_state == S_WAIT_A) w_iss_opa = bus.opa;
                else                     w_iss_opb = bus.opb;
                if ((r_state == S_WAIT_A) ? bus.inp_valid[0] : bus.inp_valid[1]) begin
                    w_issue = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 5'd1;
                    // An operand on the last waiting cycle wins over the timeout.
                    if (w_cnt_next == TIMEOUT_CNT) w_err = 1'b1;
                end
                if (w_issue || w_err) begin
                    w_next_state = S_IDLE;
                    w_cnt_next   = '0;
                    w_cap_opa    = '0;
                    w_cap_opb    = '0;
                    w_cap_cmd    = '0;
                    w_cap_mode   = 1'b0;
                    w_cap_cin    = 1'b0;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else if (bus.ce) begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt         <= '0;
            r_cap_opa     <= '0;
            r_cap_opb     <= '0;
            r_cap_cmd     <= '0;
            r_cap_mode    <= 1'b0;
            r_cap_cin     <= 1'b0;
            r_issue_valid <= 1'b0;
            r_err         <= 1'b0;
            r_issue_mode  <= 1'b0;
            r_issue_cin   <= 1'b0;
            r_issue_cmd   <= '0;
            r_issue_opa   <= '0;
            r_issue_opb   <= '0;
        end else if (!bus.ce) begin
            r_issue_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_next;
            r_cap_opa     <= w_cap_opa;
            r_cap_opb     <= w_cap_opb;
            r_cap_cmd     <= w_cap_cmd;
            r_cap_mode    <= w_cap_mode;
            r_cap_cin     <= w_cap_cin;
            r_issue_valid <= w_issue;
            r_err         <= w_err;
            if (w_issue) begin
                r_issue_mode <= w_iss_mode;
                r_issue_cin  <= w_iss_cin;
                r_issue_cmd  <= w_iss_cmd;
                r_issue_opa  <= w_iss_opa;
                r_issue_opb  <= w_iss_opb;
            end
        end
    end

    assign bus.issue_valid = r_issue_valid;
    assign bus.err         = r_err;
    assign bus.issue_mode  = r_issue_mode;
    assign bus.issue_cin   = r_issue_cin;
    assign bus.issue_cmd   = r_issue_cmd;
    assign bus.issue_opa   = r_issue_opa;
    assign bus.issue_opb   = r_issue_opb;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.state_dbg   = r_state;
endmodule
